core_ctrl: RTL and testbench
============================

// Module: core_ctrl
// PURPOSE
//  Instruction sequencer for the core: replaces the testbench's hand-driven inst stream.
//  On start, runs the full kij loop (len_kij passes) and emits the registered 34-bit inst word each cycle.
//  Each pass: xmem weights->L0, L0->PE kernel load, gap, xmem activations->L0, execute, OFIFO->pmem drain.
//  With CTRL_ACC_EN it also sequences the accumulation pass over pmem.
//  Sits between the top-level/testbench and core.inst; observes core.ofifo_valid.
// PARAMETERS
//  col       8      PE columns; weight rows per kij
//  row       8      PE rows
//  len_kij   9      kernel positions (3x3)
//  len_nij   36     input pixels per tile (6x6)
//  len_onij  16     output pixels (4x4)
//  in_dim    6      input tile width
//  out_dim   4      output width
//  ker_dim   3      kernel width
//  w_base    11'h400  xmem base address of weights; kij block at w_base+kij*col
//  gap_cyc   10     idle cycles after kernel load
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   asynchronous, active-low reset
//  start        in   1   one-cycle pulse; sampled only in IDLE
//  ofifo_valid  in   1   OFIFO has a full row available
//  inst         out  34  {acc,CEN_pmem,WEN_pmem,A_pmem[10:0],CEN_xmem,WEN_xmem,A_xmem[10:0],
//                         ofifo_rd,ififo_wr,ififo_rd,l0_rd,l0_wr,execute,load}; registered
//  busy         out  1   high from cycle after start until done
//  done         out  1   one-cycle pulse at sequence end
//  kij_idx      out  4   current pass index
// BEHAVIOUR
//  Reset: FSM=IDLE; inst=34'h1_800C_0000 (CEN/WEN high, all else 0); busy=0, done=0, kij_idx=0.
//  All inst fields are flops; every field not named in a state holds its idle value.
//  SRAM read latency is 1: the L0 write for a read at cycle c is asserted at c+1.
//  States:
//  - IDLE: start=1 -> WRD, kij=0.
//  - WRD (col+1 cyc): t=0..col-1 CEN_x=0, WEN_x=1, A_x=w_base+kij*col+t; l0_wr at t=1..col.
//  - KLD (row+col cyc): l0_rd=1, load=1.
//  - GAP (gap_cyc cyc): load=0, l0_rd=0.
//  - XRD (len_nij+1 cyc): A_x=0..len_nij-1 read; l0_wr delayed 1.
//  - EXE (len_nij cyc): l0_rd=1, execute=1.
//  - DRN: ofifo_rd=ofifo_valid; same cycle CEN_p=0, WEN_p=0, A_p=kij*len_nij+n; n++ per write.
//    n==len_nij-1 written: kij==len_kij-1 -> FIN (or ACC); else kij++ -> WRD.
//  - FIN: done=1 one cycle, busy=0 -> IDLE.
//  DRN waits indefinitely with no timeout; no pmem write in cycles with ofifo_valid=0.
//  start while busy: ignored. Reset mid-sequence: immediate return to reset values; no partial resume.
//  A_x/A_p are 11-bit; the address math must not overflow (len_kij*len_nij=324 < 2048).
// CONFIGURATION
//  CTRL_ACC_EN defined: DRN last pass -> ACC instead of FIN.
//   ACC: for o=0..len_onij-1 (oy=o/out_dim, ox=o%out_dim), one reset-gap cycle, then
//   j=0..len_kij-1 (ki=j/ker_dim, kj=j%ker_dim) reads CEN_p=0, WEN_p=1,
//   A_p=j*len_nij+(oy+ki)*in_dim+(ox+kj); acc=1 on cycles j=1..len_kij (1 after read).
//   One idle cycle follows, then the next o. After o=len_onij-1 -> FIN.
//  Not defined: ACC state absent; acc bit tied 0; DRN last pass -> FIN.
// TESTING
//  1 reset low mid-EXE at kij=3 -> next cycle inst=34'h1_800C_0000, busy=0; a new start runs from kij=0.
//  2 start, kij=0 -> WRD: A_xmem=0x400..0x407 on 8 consecutive cycles, l0_wr high 8 cycles starting one cycle later.
//  3 ofifo_valid held 1 -> 36 pmem writes at A_p 0..35 in kij=0; kij=8 -> 288..323; done after 9 passes.
//  4 ofifo_valid toggling 1/0 -> exactly 36 writes per pass; ofifo_rd never high when valid=0.
//  5 start pulse in EXE -> sequence unchanged; done pulses exactly once.
//  6 CTRL_ACC_EN, o=5 (oy=1,ox=1) -> A_p sequence 7,8,9,13,14,15,19,20,21 (+j*36); acc high 9 cycles.

Source files
------------

// File: rtl/core_ctrl_if.sv
// Sequencer handshake bundle: start/ofifo_valid in, inst word and status out.
// master = core_ctrl side, slave = top-level/testbench side.
interface core_ctrl_if;
    logic        start;
    logic        ofifo_valid;
    logic [33:0] inst;
    logic        busy;
    logic        done;
    logic [3:0]  kij_idx;

    modport master (input start, ofifo_valid, output inst, busy, done, kij_idx);
    modport slave  (output start, ofifo_valid, input inst, busy, done, kij_idx);
endinterface

// File: rtl/core_ctrl.sv
// Instruction sequencer for the core: runs len_kij passes of weight load, kernel load,
// activation load, execute and OFIFO drain. Define CTRL_ACC_EN to add the pmem accumulation pass.
//
// state | meaning
// IDLE  | waiting for start
// WRD   | xmem weight block -> L0
// KLD   | L0 -> PE kernel load
// GAP   | settle cycles after kernel load
// XRD   | xmem activations -> L0
// EXE   | stream activations through the array
// DRN   | OFIFO rows -> pmem, one write per valid row
// ACC   | pmem accumulation reads (CTRL_ACC_EN only)
// FIN   | one-cycle done pulse
module core_ctrl #(
    parameter int          col      = 8,
    parameter int          row      = 8,
    parameter int          len_kij  = 9,
    parameter int          len_nij  = 36,
    parameter int          len_onij = 16,
    parameter int          in_dim   = 6,
    parameter int          out_dim  = 4,
    parameter int          ker_dim  = 3,
    parameter logic [10:0] w_base   = 11'h400,
    parameter int          gap_cyc  = 10
) (
    input  logic        clk,
    input  logic        reset,
    core_ctrl_if.master bus
);
    localparam logic [33:0] INST_IDLE = 34'h1_800C_0000;
    localparam int ACC_A_MAX = (len_kij - 1) * len_nij + (out_dim + ker_dim - 2) * (in_dim + 1);

    if (len_kij * len_nij > 2048 || ACC_A_MAX > 2047 || len_onij > out_dim * out_dim) begin : g_geom_check
        $fatal(1, "core_ctrl: geometry overflows the 11-bit pmem address");
    end

    localparam logic [7:0] WRD_LAST = 8'(col);
    localparam logic [7:0] XRD_LAST = 8'(len_nij);
    localparam logic [7:0] DRN_LAST = 8'(len_nij - 1);
    localparam logic [7:0] KLD_TC   = 8'(row + col - 1);
    localparam logic [7:0] GAP_TC   = 8'(gap_cyc - 1);
    localparam logic [7:0] EXE_TC   = 8'(len_nij - 1);
    localparam logic [3:0] KIJ_LAST = 4'(len_kij - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_WRD, S_KLD, S_GAP, S_XRD, S_EXE, S_DRN, S_FIN
`ifdef CTRL_ACC_EN
        , S_ACC
`endif
    } state_t;

    state_t      state, nxt_state;
    logic [7:0]  idx, nxt_idx;
    logic [7:0]  tmr, nxt_tmr;
    logic [3:0]  kij, nxt_kij;
    logic [33:0] inst_q, inst_d;
    logic        busy_q, done_q;

`ifdef CTRL_ACC_EN
    localparam logic [3:0] PH_LAST = 4'(len_kij + 1);
    localparam logic [4:0] O_LAST  = 5'(len_onij - 1);

    // ph 0 is the reset gap, ph 1..len_kij read j=ph-1, last ph only finishes the acc tail
    logic [4:0]  o_idx, nxt_o;
    logic [3:0]  ph, nxt_ph;
    logic [10:0] acc_addr;

    assign acc_addr = 11'((int'(ph) - 1) * len_nij
                        + (int'(o_idx) / out_dim + (int'(ph) - 1) / ker_dim) * in_dim
                        + int'(o_idx) % out_dim + (int'(ph) - 1) % ker_dim);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            idx    <= '0;
            tmr    <= '0;
            kij    <= '0;
            inst_q <= INST_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
`ifdef CTRL_ACC_EN
            o_idx  <= '0;
            ph     <= '0;
`endif
        end else begin
            state  <= nxt_state;
            idx    <= nxt_idx;
            tmr    <= nxt_tmr;
            kij    <= nxt_kij;
            inst_q <= inst_d;
            busy_q <= (nxt_state != S_IDLE) && (nxt_state != S_FIN);
            done_q <= (nxt_state == S_FIN);
`ifdef CTRL_ACC_EN
            o_idx  <= nxt_o;
            ph     <= nxt_ph;
`endif
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_idx   = idx;
        nxt_tmr   = tmr;
        nxt_kij   = kij;
`ifdef CTRL_ACC_EN
        nxt_o     = o_idx;
        nxt_ph    = ph;
`endif
        case (state)
            S_IDLE: if (bus.start) begin
                nxt_state = S_WRD;
                nxt_idx   = '0;
                nxt_kij   = '0;
            end
            S_WRD: if (idx == WRD_LAST) begin
                nxt_state = S_KLD;
                nxt_tmr   = KLD_TC;
            end else nxt_idx = idx + 8'd1;
            S_KLD: if (tmr == '0) begin
                nxt_state = S_GAP;
                nxt_tmr   = GAP_TC;
            end else nxt_tmr = tmr - 8'd1;
            S_GAP: if (tmr == '0) begin
                nxt_state = S_XRD;
                nxt_idx   = '0;
            end else nxt_tmr = tmr - 8'd1;
            S_XRD: if (idx == XRD_LAST) begin
                nxt_state = S_EXE;
                nxt_tmr   = EXE_TC;
            end else nxt_idx = idx + 8'd1;
            S_EXE: if (tmr == '0) begin
                nxt_state = S_DRN;
                nxt_idx   = '0;
            end else nxt_tmr = tmr - 8'd1;
            // idx counts rows written this pass; no timeout while OFIFO is empty
            S_DRN: if (bus.ofifo_valid) begin
                if (idx == DRN_LAST) begin
                    if (kij == KIJ_LAST) begin
`ifdef CTRL_ACC_EN
                        nxt_state = S_ACC;
                        nxt_o     = '0;
                        nxt_ph    = '0;
`else
                        nxt_state = S_FIN;
`endif
                    end else begin
                        nxt_state = S_WRD;
                        nxt_kij   = kij + 4'd1;
                        nxt_idx   = '0;
                    end
                end else nxt_idx = idx + 8'd1;
            end
`ifdef CTRL_ACC_EN
            S_ACC: if (ph == PH_LAST) begin
                nxt_ph = '0;
                if (o_idx == O_LAST) nxt_state = S_FIN;
                else nxt_o = o_idx + 5'd1;
            end else nxt_ph = ph + 4'd1;
`endif
            S_FIN: nxt_state = S_IDLE;
            default: nxt_state = S_IDLE;
        endcase
    end

    logic        acc_b, cen_p, wen_p, cen_x, wen_x;
    logic        ofifo_rd, l0_rd, l0_wr, execute, load;
    logic [10:0] a_p, a_x;

    always_comb begin
        acc_b    = 1'b0;
        cen_p    = 1'b1;
        wen_p    = 1'b1;
        a_p      = '0;
        cen_x    = 1'b1;
        wen_x    = 1'b1;
        a_x      = '0;
        ofifo_rd = 1'b0;
        l0_rd    = 1'b0;
        l0_wr    = 1'b0;
        execute  = 1'b0;
        load     = 1'b0;
        case (state)
            // L0 write trails the xmem read by the one-cycle SRAM latency
            S_WRD: begin
                if (idx < WRD_LAST) begin
                    cen_x = 1'b0;
                    a_x   = w_base + 11'(int'(kij) * col) + 11'(idx);
                end
                l0_wr = (idx != '0);
            end
            S_KLD: begin
                l0_rd = 1'b1;
                load  = 1'b1;
            end
            S_XRD: begin
                if (idx < XRD_LAST) begin
                    cen_x = 1'b0;
                    a_x   = 11'(idx);
                end
                l0_wr = (idx != '0);
            end
            S_EXE: begin
                l0_rd   = 1'b1;
                execute = 1'b1;
            end
            S_DRN: begin
                ofifo_rd = bus.ofifo_valid;
                if (bus.ofifo_valid) begin
                    cen_p = 1'b0;
                    wen_p = 1'b0;
                    a_p   = 11'(int'(kij) * len_nij + int'(idx));
                end
            end
`ifdef CTRL_ACC_EN
            S_ACC: begin
                if (ph != '0 && ph <= 4'(len_kij)) begin
                    cen_p = 1'b0;
                    a_p   = acc_addr;
                end
                acc_b = (ph >= 4'd2);
            end
`endif
            default: ;
        endcase
        inst_d = {acc_b, cen_p, wen_p, a_p, cen_x, wen_x, a_x,
                  ofifo_rd, 1'b0, 1'b0, l0_rd, l0_wr, execute, load};
    end

    assign bus.inst    = inst_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.kij_idx = kij;
endmodule

// File: tb/tb_core_ctrl.sv
// Self-checking bench for core_ctrl: full sequences under held, toggling and random
// ofifo_valid, a mid-run reset and a start pulse while busy, against a queue-based model.
module tb_core_ctrl;
    localparam int COL = 8, ROW = 8, KIJ = 9, NIJ = 36, ONIJ = 16;
    localparam int IN_DIM = 6, OUT_DIM = 4, KER = 3, GAP = 10;
    localparam int WB = 'h400;
    localparam logic [33:0] INST_IDLE = 34'h1_800C_0000;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    core_ctrl_if bus ();

    core_ctrl #(
        .col(COL), .row(ROW), .len_kij(KIJ), .len_nij(NIJ), .len_onij(ONIJ),
        .in_dim(IN_DIM), .out_dim(OUT_DIM), .ker_dim(KER), .w_base(11'h400), .gap_cyc(GAP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic        acc, cen_p, wen_p, cen_x, wen_x, ofifo_rd, l0_rd, l0_wr, execute, load;
    logic [10:0] a_p, a_x;
    assign {acc, cen_p, wen_p, a_p, cen_x, wen_x, a_x, ofifo_rd} = bus.inst[33:6];
    assign l0_rd   = bus.inst[3];
    assign l0_wr   = bus.inst[2];
    assign execute = bus.inst[1];
    assign load    = bus.inst[0];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // vmode: 0 valid held high, 1 toggling 1/0, 2 random
    task automatic run(input int vmode, input int abort_kij, input bit poke_exe);
        logic [10:0] x_q[$];
        logic [10:0] p_q[$];
        logic [10:0] r_q[$];
        int          k_q[$];
        int cyc = 0, done_cnt = 0, load_cnt = 0, exe_cnt = 0, l0rd_cnt = 0, wr_cnt = 0;
        int last_x = -10;
        int ek;
        bit prev_x = 0, prev_pr = 0, prev_v = 0, poked = 0, fin = 0, aborted = 0;
        bit v, xr, pr;
        logic [10:0] e;

        for (int k = 0; k < KIJ; k++) begin
            for (int t = 0; t < COL; t++) begin
                x_q.push_back(11'(WB + k * COL + t));
                k_q.push_back(k);
            end
            for (int n = 0; n < NIJ; n++) begin
                x_q.push_back(11'(n));
                k_q.push_back(-1);
            end
            for (int n = 0; n < NIJ; n++) p_q.push_back(11'(k * NIJ + n));
        end
`ifdef CTRL_ACC_EN
        for (int o = 0; o < ONIJ; o++)
            for (int j = 0; j < KIJ; j++)
                r_q.push_back(11'(j * NIJ + (o / OUT_DIM + j / KER) * IN_DIM + o % OUT_DIM + j % KER));
`endif

        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        chk("busy_after_start", bus.busy, 1);

        while (!fin && !aborted && cyc < 6000) begin
            xr = !cen_x;
            pr = !cen_p && wen_p;
            chk("ififo_idle", bus.inst[5:4], 0);
            chk("wen_x", wen_x, 1);
            chk("l0_wr_lag", l0_wr, prev_x);
            chk("acc_lag", acc, prev_pr);
            chk("pwr_eq_ofifo_rd", !cen_p && !wen_p, ofifo_rd);
            if (ofifo_rd) chk("ofifo_rd_valid", prev_v, 1);
            if (xr) begin
                chk("x_left", x_q.size() > 0, 1);
                if (x_q.size() > 0) begin
                    e  = x_q.pop_front();
                    ek = k_q.pop_front();
                    chk("a_xmem", a_x, e);
                    if (ek >= 0) chk("kij_idx", bus.kij_idx, ek);
                    if (e != 11'(ek >= 0 ? WB + ek * COL : 0)) chk("x_consec", cyc, last_x + 1);
                end
                last_x = cyc;
            end
            if (!cen_p && !wen_p) begin
                wr_cnt++;
                chk("p_left", p_q.size() > 0, 1);
                if (p_q.size() > 0) chk("a_pmem_wr", a_p, p_q.pop_front());
            end
            if (pr) begin
                chk("r_left", r_q.size() > 0, 1);
                if (r_q.size() > 0) chk("a_pmem_rd", a_p, r_q.pop_front());
            end
            load_cnt += int'(load);
            exe_cnt  += int'(execute);
            l0rd_cnt += int'(l0_rd);
            if (bus.done) begin
                done_cnt++;
                chk("busy_at_done", bus.busy, 0);
                fin = 1;
            end else chk("busy_run", bus.busy, 1);

            if (!fin && abort_kij >= 0 && int'(bus.kij_idx) == abort_kij && execute) begin
                reset = 1'b0;
                #1;
                chk("abort_inst", bus.inst, INST_IDLE);
                chk("abort_busy", bus.busy, 0);
                chk("abort_kij", bus.kij_idx, 0);
                #2 reset = 1'b1;
                aborted = 1;
            end

            bus.start = 1'b0;
            if (poke_exe && !poked && execute) begin
                bus.start = 1'b1;
                poked = 1;
            end
            case (vmode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(1));
            endcase
            bus.ofifo_valid = v;
            prev_v  = v;
            prev_x  = xr;
            prev_pr = pr;
            tick;
            cyc++;
        end
        bus.start       = 1'b0;
        bus.ofifo_valid = 1'b0;
        if (aborted) return;

        chk("finished", fin, 1);
        chk("inst_idle_after", bus.inst, INST_IDLE);
        for (int i = 0; i < 3; i++) begin
            chk("idle_busy", bus.busy, 0);
            if (bus.done) done_cnt++;
            tick;
        end
        chk("done_once", done_cnt, 1);
        chk("x_empty", x_q.size(), 0);
        chk("p_empty", p_q.size(), 0);
        chk("r_empty", r_q.size(), 0);
        chk("wr_cnt", wr_cnt, KIJ * NIJ);
        chk("load_cnt", load_cnt, KIJ * (ROW + COL));
        chk("exe_cnt", exe_cnt, KIJ * NIJ);
        chk("l0rd_cnt", l0rd_cnt, KIJ * (ROW + COL + NIJ));
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.ofifo_valid = 1'b0;
        #2 reset = 1'b0;
        repeat (3) tick;
        chk("rst_inst", bus.inst, INST_IDLE);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_kij", bus.kij_idx, 0);
        #2 reset = 1'b1;
        tick;
        chk("idle_inst", bus.inst, INST_IDLE);

        run(2, 3, 1'b0);
        tick;
        chk("post_abort_inst", bus.inst, INST_IDLE);
        chk("post_abort_busy", bus.busy, 0);
        run(0, -1, 1'b0);
        run(1, -1, 1'b0);
        run(2, -1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
